// File: rtl/intc_irq_ctrl.sv
// rtl/intc_irq_ctrl.sv - external interrupt controller feeding CPU int_i[5:0] over a Wishbone slave
// Optional word-7 software trigger enabled by defining INTC_SWTRIG_EN.
module intc_irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src_i,
  output logic [5:0]       int_o,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o
);

  // One sampling flop beyond the synchroniser so level and edge paths share
  // the same SYNC_STAGES+1 edge latency to int_o.
  localparam int NS = SYNC_STAGES + 1;

  logic [N_SRC-1:0]   sync_q [NS];
  logic [N_SRC-1:0]   enable_q, mode_q, pol_q, edge_q, act_prev_q;
  logic [3*N_SRC-1:0] route_q;

  logic [N_SRC-1:0] raw, act, rise, pending, active, wd, clr_v, set_v, edge_n;
  logic             bus_req, wr_en;
  logic [2:0]       idx;
  logic [31:0]      rdata;
  logic [5:0]       int_n;
  logic             unused_bits;

  function automatic logic [3*N_SRC-1:0] route_rst();
    logic [3*N_SRC-1:0] r;
    r = '0;
    for (int k = 0; k < N_SRC; k++) r[3*k +: 3] = (k < 6) ? 3'(k) : 3'd7;
    return r;
  endfunction

  assign raw     = sync_q[NS-1];
  assign act     = raw ^ pol_q;
  assign rise    = act & ~act_prev_q & mode_q;
  // Edge sources expose a fresh rise immediately, before it lands in edge_q.
  assign pending = (mode_q & (edge_q | rise)) | (~mode_q & act);
  assign active  = pending & enable_q;

  assign bus_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en       = bus_req & wb_we_i;
  assign idx         = wb_adr_i[4:2];
  assign wd          = wb_dat_i[N_SRC-1:0];
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    clr_v = '0;
    set_v = rise;
    if (wr_en && idx == 3'd0) clr_v = wd;
`ifdef INTC_SWTRIG_EN
    if (wr_en && idx == 3'd7) set_v = set_v | (wd & mode_q);
`endif
    edge_n = (edge_q & ~clr_v) | set_v;
    if (wr_en && idx == 3'd2) edge_n = edge_n & wd;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata[N_SRC-1:0]   = pending;
      3'd1:    rdata[N_SRC-1:0]   = enable_q;
      3'd2:    rdata[N_SRC-1:0]   = mode_q;
      3'd3:    rdata[N_SRC-1:0]   = pol_q;
      3'd4:    rdata[3*N_SRC-1:0] = route_q;
      3'd5:    rdata[N_SRC-1:0]   = raw;
      3'd6:    rdata[N_SRC-1:0]   = active;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    int_n = '0;
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (active[k] && route_q[3*k +: 3] == 3'(j)) int_n[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) sync_q[s] <= '0;
      act_prev_q <= '0;
      edge_q     <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pol_q      <= '0;
      route_q    <= route_rst();
      int_o      <= '0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int s = 1; s < NS; s++) sync_q[s] <= sync_q[s-1];
      act_prev_q <= act;
      edge_q     <= edge_n;
      int_o      <= int_n;
      wb_ack_o   <= bus_req;
      wb_dat_o   <= (bus_req && !wb_we_i) ? rdata : 32'd0;
      if (wr_en) begin
        case (idx)
          3'd1:    enable_q <= wd;
          3'd2:    mode_q   <= wd;
          3'd3:    pol_q    <= wd;
          3'd4:    route_q  <= wb_dat_i[3*N_SRC-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intc_irq_ctrl.sv
// tb/tb_intc_irq_ctrl.sv - directed and randomized bench for intc_irq_ctrl against a delay-line model
module tb_intc_irq_ctrl;

  localparam int LAT = 3;  // source sample edge to int_o update, in edges

`ifdef INTC_SWTRIG_EN
  localparam logic [31:0] SW_EXP = 32'h08;
`else
  localparam logic [31:0] SW_EXP = 32'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src_i;
  logic [5:0]  int_o;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;

  intc_irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_src_i(irq_src_i), .int_o(int_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_en, m_mode, m_pol, m_stored, m_last, m_pend, snap_pend;
  logic [23:0] m_route;
  logic [7:0]  h [LAT+2];
  logic [5:0]  m_int;
  logic [31:0] r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset_cfg();
    m_en = 8'h00; m_mode = 8'h00; m_pol = 8'h00; m_route = 24'hFEC688;
  endtask

  // Source seen LAT edges ago decides level pending; its rise versus the one before latches edge pending.
  task automatic model_step();
    logic [7:0] a, ap;
    if (rst) begin
      for (int i = 0; i < LAT+2; i++) h[i] = 8'h00;
      m_stored = 8'h00; m_last = 8'h00; m_pend = 8'h00; m_int = 6'd0;
    end else begin
      for (int i = LAT+1; i > 0; i--) h[i] = h[i-1];
      h[0] = irq_src_i;
      a  = h[LAT]   ^ m_pol;
      ap = h[LAT+1] ^ m_pol;
      m_last   = m_mode & a & ~ap;
      m_stored = m_stored | m_last;
      m_pend   = (m_mode & m_stored) | (~m_mode & a);
      m_int    = 6'd0;
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 6; j++)
          if (m_pend[k] && m_en[k] && m_route[3*k +: 3] == 3'(j)) m_int[j] = 1'b1;
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_step();
    #1;
    chk("int_o", 32'(int_o), 32'(m_int));
  endtask

  task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
    wb_adr_i = {idx, 2'b00}; wb_dat_i = wd;
    clk_edge();
    chk("ack_rise", 32'(wb_ack_o), 32'd1);
    rd = wb_dat_o;
    snap_pend = m_pend;
    if (w) begin
      case (idx)
        3'd0: m_stored = m_stored & ~(wd[7:0] & ~m_last);
        3'd1: m_en = wd[7:0];
        3'd2: begin m_mode = wd[7:0]; m_stored = m_stored & m_mode; end
        3'd3: m_pol = wd[7:0];
        3'd4: m_route = wd[23:0];
        3'd7: begin
`ifdef INTC_SWTRIG_EN
          m_stored = m_stored | (wd[7:0] & m_mode);
`endif
        end
        default: ;
      endcase
    end
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    clk_edge();
    chk("ack_pulse", 32'(wb_ack_o), 32'd0);
    chk("dat_idle", wb_dat_o, 32'd0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, idx, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, idx, 32'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic set_src(input logic [7:0] v);
    @(negedge clk);
    irq_src_i = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_edge();
    end
  endtask

  initial begin
    rst = 1'b1; irq_src_i = 8'h00;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 5'd0; wb_dat_i = 32'd0;
    model_reset_cfg();
    repeat (3) clk_edge();
    @(negedge clk); rst = 1'b0;
    clk_edge();
    chk("ack_rst", 32'(wb_ack_o), 32'd0);
    chk("dat_rst", wb_dat_o, 32'd0);
    rd_chk("route_rst", 3'd4, 32'h00FEC688);
    rd_chk("en_rst", 3'd1, 32'd0);
    rd_chk("mode_rst", 3'd2, 32'd0);
    rd_chk("pend_rst", 3'd0, 32'd0);

    // held strobe: ack toggles, data only while acked
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd16;
    for (int e = 0; e < 4; e++) begin
      clk_edge();
      chk("held_ack", 32'(wb_ack_o), (e % 2 == 0) ? 32'd1 : 32'd0);
      chk("held_dat", wb_dat_o, (e % 2 == 0) ? 32'h00FEC688 : 32'd0);
    end
    @(negedge clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    clk_edge();

    // level mode latency
    wr(3'd1, 32'h01);
    set_src(8'h01);
    for (int e = 1; e <= 4; e++) begin
      clk_edge();
      chk("lvl_rise", 32'(int_o), (e == 4) ? 32'h01 : 32'h00);
    end
    rd_chk("lvl_pend", 3'd0, 32'h01);
    set_src(8'h00);
    for (int e = 1; e <= 4; e++) begin
      clk_edge();
      chk("lvl_fall", 32'(int_o), (e == 4) ? 32'h00 : 32'h01);
    end

    // edge mode: short pulse latches until cleared
    wr(3'd2, 32'h04);
    wr(3'd1, 32'h04);
    set_src(8'h04); clk_edge();
    tick(1);
    set_src(8'h00); clk_edge();
    tick(5);
    chk("edge_held", 32'(int_o), 32'h04);
    rd_chk("edge_pend", 3'd0, 32'h04);
    wr(3'd0, 32'h04);
    chk("edge_clr", 32'(int_o), 32'h00);

    // clear committed on the edge a new rise registers: set wins
    set_src(8'h04); clk_edge();
    tick(2);
    wr(3'd0, 32'h04);
    rd_chk("collide_pend", 3'd0, 32'h04);
    set_src(8'h00); clk_edge();
    wr(3'd0, 32'h04);
    wr(3'd2, 32'h00);
    rd_chk("collide_clr", 3'd0, 32'h00);

    // routing and polarity
    wr(3'd4, 32'h00F6C688);
    wr(3'd1, 32'h40);
    set_src(8'h40); clk_edge();
    tick(4);
    chk("route6", 32'(int_o), 32'h20);
    set_src(8'h00); clk_edge();
    wr(3'd3, 32'h02);
    wr(3'd1, 32'h02);
    tick(4);
    chk("pol1", 32'(int_o), 32'h02);
    rd_chk("raw", 3'd5, 32'h00);
    rd_chk("active", 3'd6, 32'h02);

    // software trigger
    wr(3'd3, 32'h00);
    wr(3'd2, 32'h08);
    wr(3'd1, 32'h08);
    wr(3'd7, 32'h08);
    chk("swt_int", 32'(int_o), SW_EXP);
    rd_chk("swt_pend", 3'd0, SW_EXP);
    rd_chk("swt_rd", 3'd7, 32'h00);
    wr(3'd0, 32'h08);

    // randomized configurations and source activity
    for (int round = 0; round < 6; round++) begin
      wr(3'd2, 32'h00);
      wr(3'd3, 32'($urandom_range(0, 255)));
      wr(3'd1, 32'($urandom_range(0, 255)));
      wr(3'd4, {8'h00, 24'($urandom)});
      wr(3'd2, 32'($urandom_range(0, 255)));
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) irq_src_i = irq_src_i ^ 8'($urandom);
        clk_edge();
        if (c % 15 == 7) begin
          bus(1'b0, 3'd0, 32'd0, r);
          chk("rnd_pend", r, 32'(snap_pend));
          bus(1'b0, 3'd6, 32'd0, r);
          chk("rnd_active", r, 32'(snap_pend & m_en));
        end
        if (c % 20 == 13) wr(3'd0, 32'($urandom_range(0, 255)));
      end
    end

    // reset in the middle of a write discards it
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 5'd4; wb_dat_i = 32'hFF;
    rst = 1'b1;
    model_reset_cfg();
    clk_edge();
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; rst = 1'b0; irq_src_i = 8'h00;
    clk_edge();
    rd_chk("rst_wr_drop", 3'd1, 32'd0);
    rd_chk("rst_route", 3'd4, 32'h00FEC688);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
